stopwatch_controller: RTL and testbench

STOPWATCH_CONTROLLER -- requirements
Module: stopwatch_controller

---
 rtl/stopwatch_pkg.sv | 15 +
 rtl/button_debouncer.sv | 52 +++++
 rtl/stopwatch_controller.sv | 148 ++++++++++++++
 tb/tb_stopwatch_controller.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared encodings and bus widths for the stopwatch controller.
package stopwatch_pkg;

    localparam int STATE_W    = 2;
    localparam int DIGIT_W    = 2;
    localparam int NUM_DIGITS = 4;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        LAP   = 2'd3
    } state_t;

endpackage

// File: rtl/button_debouncer.sv
// Button front end: 2-flop synchronizer, tick-sampled debouncer, press pulse.
// The press pulse is suppressed after reset until the button has been seen released.
module button_debouncer #(
    parameter int unsigned SAMPLES = 3
) (
    input  logic clock,
    input  logic reset_n,
    input  logic tick,
    input  logic raw,
    output logic press
);

    localparam int CW = $clog2(SAMPLES + 1);

    logic [1:0]    sync;
    logic          level;
    logic          level_d;
    logic          armed;
    logic [CW-1:0] streak;

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync    <= '0;
            level   <= 1'b0;
            level_d <= 1'b0;
            armed   <= 1'b0;
            streak  <= '0;
        end else begin
            sync    <= {sync[0], raw};
            level_d <= level;
            if (tick) begin
                if (!sync[1]) begin
                    armed <= 1'b1;
                end
                if (sync[1] != level) begin
                    if (streak == CW'(SAMPLES - 1)) begin
                        level  <= sync[1];
                        streak <= '0;
                    end else begin
                        streak <= streak + 1'b1;
                    end
                end else begin
                    streak <= '0;
                end
            end
        end
    end

    assign press = armed & level & ~level_d;

endmodule

// File: rtl/stopwatch_controller.sv
// Stopwatch control FSM driving an external 4-digit BCD counter chain,
// plus count tick generation and display digit scanning.
module stopwatch_controller
    import stopwatch_pkg::*;
#(
    parameter int unsigned TICK_DIV         = 65536,
    parameter int unsigned SCAN_DIV         = 4,
    parameter int unsigned DEBOUNCE_SAMPLES = 3
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  btn_start_stop,
    input  logic                  btn_lap_clear,
    input  logic                  count_max,
    output logic                  count_en,
    output logic                  count_clr,
    output logic                  display_freeze,
    output logic [DIGIT_W-1:0]    digit_idx,
    output logic [NUM_DIGITS-1:0] digit_sel,
    output logic [STATE_W-1:0]    state,
    output logic                  overflow_flag
);

    localparam int TW = $clog2(TICK_DIV);
    localparam int SW = $clog2(SCAN_DIV + 1);

    logic [TW-1:0] tick_cnt;
    logic [SW-1:0] scan_cnt;
    logic          tick;
    logic          ss_press;
    logic          lc_press;

    state_t state_q;
    state_t state_next;
    logic   freeze_next;
    logic   ovf_next;
    logic   en_next;
    logic   clr_next;
    logic   active;

    assign tick = (tick_cnt == TW'(TICK_DIV - 1));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            scan_cnt  <= '0;
            digit_idx <= '0;
        end else if (scan_cnt == SW'(SCAN_DIV - 1)) begin
            scan_cnt  <= '0;
            digit_idx <= digit_idx + 1'b1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    assign digit_sel = NUM_DIGITS'(1) << digit_idx;

    button_debouncer #(.SAMPLES(DEBOUNCE_SAMPLES)) u_start_stop (
        .clock   (clock),
        .reset_n (reset_n),
        .tick    (tick),
        .raw     (btn_start_stop),
        .press   (ss_press)
    );

    button_debouncer #(.SAMPLES(DEBOUNCE_SAMPLES)) u_lap_clear (
        .clock   (clock),
        .reset_n (reset_n),
        .tick    (tick),
        .raw     (btn_lap_clear),
        .press   (lc_press)
    );

    // Saturation outranks button events; start_stop outranks lap_clear.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_next  = state_q;
        freeze_next = display_freeze;
        ovf_next    = overflow_flag;
        en_next     = 1'b0;
        clr_next    = 1'b0;
        active      = (state_q == RUN) || (state_q == LAP);

        if (tick && active && count_max) begin
            state_next  = PAUSE;
            ovf_next    = 1'b1;
            freeze_next = 1'b0;
        end else begin
            en_next = tick && active;
            if (ss_press) begin
                case (state_q)
                    IDLE:  state_next = RUN;
                    RUN:   state_next = PAUSE;
                    LAP: begin
                        state_next  = PAUSE;
                        freeze_next = 1'b0;
                    end
                    PAUSE: state_next = RUN;
                endcase
            end else if (lc_press) begin
                case (state_q)
                    IDLE:  clr_next = 1'b1;
                    RUN: begin
                        state_next  = LAP;
                        freeze_next = 1'b1;
                    end
                    LAP: begin
                        state_next  = RUN;
                        freeze_next = 1'b0;
                    end
                    PAUSE: begin
                        state_next = IDLE;
                        clr_next   = 1'b1;
                        ovf_next   = 1'b0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            display_freeze <= 1'b0;
            overflow_flag  <= 1'b0;
            count_en       <= 1'b0;
            count_clr      <= 1'b0;
        end else begin
            state_q        <= state_next;
            display_freeze <= freeze_next;
            overflow_flag  <= ovf_next;
            count_en       <= en_next;
            count_clr      <= clr_next;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_stopwatch_controller.sv
// Self-checking bench for stopwatch_controller: directed scenarios then random
// button/count_max activity, all compared every cycle against a behavioural model.
module tb_stopwatch_controller;

    localparam int TD = 4;
    localparam int SD = 2;
    localparam int DS = 2;

    localparam int S_IDLE  = 0;
    localparam int S_RUN   = 1;
    localparam int S_PAUSE = 2;
    localparam int S_LAP   = 3;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       btn_start_stop;
    logic       btn_lap_clear;
    logic       count_max;
    logic       count_en;
    logic       count_clr;
    logic       display_freeze;
    logic [1:0] digit_idx;
    logic [3:0] digit_sel;
    logic [1:0] state;
    logic       overflow_flag;

    int checks = 0;
    int errors = 0;
    int en_seen;
    int clr_seen;

    // Reference model: cycles since reset, FSM state as a spec code, and per
    // button the raw history, accepted level, run of differing samples and events.
    int m_cyc;
    int m_state;
    bit m_en, m_clr, m_frz, m_ovf;
    bit d1[2], d2[2], lvl[2], armed[2], ev[2];
    int streak[2];

    always #5 clock = ~clock;

    stopwatch_controller #(
        .TICK_DIV         (TD),
        .SCAN_DIV         (SD),
        .DEBOUNCE_SAMPLES (DS)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .btn_start_stop (btn_start_stop),
        .btn_lap_clear  (btn_lap_clear),
        .count_max      (count_max),
        .count_en       (count_en),
        .count_clr      (count_clr),
        .display_freeze (display_freeze),
        .digit_idx      (digit_idx),
        .digit_sel      (digit_sel),
        .state          (state),
        .overflow_flag  (overflow_flag)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cyc   = 0;
        m_state = S_IDLE;
        m_en    = 1'b0;
        m_clr   = 1'b0;
        m_frz   = 1'b0;
        m_ovf   = 1'b0;
        for (int b = 0; b < 2; b++) begin
            d1[b] = 1'b0; d2[b] = 1'b0; lvl[b] = 1'b0;
            armed[b] = 1'b0; ev[b] = 1'b0; streak[b] = 0;
        end
    endtask

    task automatic model_edge();
        bit tick_now;
        bit act;
        bit raw_now[2];
        bit new_ev[2];
        if (!reset_n) begin
            model_reset();
            return;
        end
        tick_now = (m_cyc % TD) == TD - 1;
        act      = (m_state == S_RUN) || (m_state == S_LAP);
        m_clr    = 1'b0;
        m_en     = tick_now && act && !count_max;
        if (tick_now && act && count_max) begin
            m_state = S_PAUSE; m_ovf = 1'b1; m_frz = 1'b0;
        end else if (ev[0]) begin
            case (m_state)
                S_IDLE:  m_state = S_RUN;
                S_RUN:   m_state = S_PAUSE;
                S_LAP:   begin m_state = S_PAUSE; m_frz = 1'b0; end
                default: m_state = S_RUN;
            endcase
        end else if (ev[1]) begin
            case (m_state)
                S_IDLE:  m_clr = 1'b1;
                S_RUN:   begin m_state = S_LAP; m_frz = 1'b1; end
                S_LAP:   begin m_state = S_RUN; m_frz = 1'b0; end
                default: begin m_state = S_IDLE; m_clr = 1'b1; m_ovf = 1'b0; end
            endcase
        end
        raw_now[0] = btn_start_stop;
        raw_now[1] = btn_lap_clear;
        for (int b = 0; b < 2; b++) begin
            new_ev[b] = 1'b0;
            if (tick_now) begin
                if (d2[b] != lvl[b]) begin
                    streak[b]++;
                    if (streak[b] == DS) begin
                        lvl[b]    = d2[b];
                        streak[b] = 0;
                        new_ev[b] = lvl[b] && armed[b];
                    end
                end else begin
                    streak[b] = 0;
                end
                if (!d2[b]) armed[b] = 1'b1;
            end
            d2[b] = d1[b];
            d1[b] = raw_now[b];
            ev[b] = new_ev[b];
        end
        m_cyc++;
    endtask

    task automatic compare_all();
        int idx;
        idx = (m_cyc / SD) % 4;
        check("state", 32'(state), 32'(m_state));
        check("count_en", 32'(count_en), 32'(m_en));
        check("count_clr", 32'(count_clr), 32'(m_clr));
        check("display_freeze", 32'(display_freeze), 32'(m_frz));
        check("overflow_flag", 32'(overflow_flag), 32'(m_ovf));
        check("digit_idx", 32'(digit_idx), 32'(idx));
        check("digit_sel", 32'(digit_sel), 32'(1 << idx));
        check("en_clr_exclusive", 32'(count_en & count_clr), 32'(0));
        if (count_en === 1'b1) en_seen++;
        if (count_clr === 1'b1) clr_seen++;
    endtask

    task automatic step();
        @(posedge clock);
        model_edge();
        @(negedge clock);
        compare_all();
    endtask

    task automatic press(input bit ss, input bit lc, input int hold_ticks);
        btn_start_stop = ss;
        btn_lap_clear  = lc;
        repeat (hold_ticks * TD) step();
        btn_start_stop = 1'b0;
        btn_lap_clear  = 1'b0;
        repeat (16) step();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_state"}, 32'(state), 32'(S_IDLE));
        check({tag, "_count_en"}, 32'(count_en), 32'(0));
        check({tag, "_count_clr"}, 32'(count_clr), 32'(0));
        check({tag, "_freeze"}, 32'(display_freeze), 32'(0));
        check({tag, "_overflow"}, 32'(overflow_flag), 32'(0));
        check({tag, "_digit_idx"}, 32'(digit_idx), 32'(0));
        check({tag, "_digit_sel"}, 32'(digit_sel), 32'(4'b0001));
    endtask

    initial begin
        int hold[2];
        reset_n        = 1'b0;
        btn_start_stop = 1'b0;
        btn_lap_clear  = 1'b0;
        count_max      = 1'b0;
        en_seen        = 0;
        clr_seen       = 0;
        model_reset();
        repeat (3) step();
        check_reset_values("reset");
        reset_n = 1'b1;

        // Scan sequence from reset release: 0,0,1,1,2,2,3,3,0,0,...
        check("scan_seq", 32'(digit_idx), 32'(0));
        for (int i = 1; i < 16; i++) begin
            step();
            check("scan_seq", 32'(digit_idx), 32'((i / 2) % 4));
            check("scan_onehot", 32'($onehot(digit_sel)), 32'(1));
        end

        // One-tick glitch is rejected.
        en_seen = 0;
        press(1'b1, 1'b0, 1);
        check("glitch_state", 32'(state), 32'(S_IDLE));
        check("glitch_no_count", 32'(en_seen), 32'(0));

        // Start, then count_en every TD cycles.
        press(1'b1, 1'b0, 3);
        check("start_state", 32'(state), 32'(S_RUN));
        en_seen = 0;
        repeat (16) step();
        check("run_en_pulses", 32'(en_seen), 32'(16 / TD));

        // Lap freeze and release.
        press(1'b0, 1'b1, 3);
        check("lap_state", 32'(state), 32'(S_LAP));
        check("lap_freeze", 32'(display_freeze), 32'(1));
        en_seen = 0;
        repeat (16) step();
        check("lap_en_pulses", 32'(en_seen), 32'(16 / TD));
        press(1'b0, 1'b1, 3);
        check("unlap_state", 32'(state), 32'(S_RUN));
        check("unlap_freeze", 32'(display_freeze), 32'(0));

        // Simultaneous presses: start_stop wins.
        press(1'b1, 1'b1, 3);
        check("both_state", 32'(state), 32'(S_PAUSE));
        check("both_freeze", 32'(display_freeze), 32'(0));

        // Saturation, then clear from PAUSE.
        press(1'b1, 1'b0, 3);
        check("resume_state", 32'(state), 32'(S_RUN));
        count_max = 1'b1;
        en_seen   = 0;
        repeat (8) step();
        check("sat_state", 32'(state), 32'(S_PAUSE));
        check("sat_overflow", 32'(overflow_flag), 32'(1));
        check("sat_no_count", 32'(en_seen), 32'(0));
        count_max = 1'b0;
        clr_seen  = 0;
        press(1'b0, 1'b1, 3);
        check("clear_pulses", 32'(clr_seen), 32'(1));
        check("clear_overflow", 32'(overflow_flag), 32'(0));
        check("clear_state", 32'(state), 32'(S_IDLE));

        // Asynchronous reset in LAP takes effect immediately.
        press(1'b1, 1'b0, 3);
        press(1'b0, 1'b1, 3);
        check("pre_reset_state", 32'(state), 32'(S_LAP));
        reset_n = 1'b0;
        model_reset();
        #1;
        check_reset_values("async_reset");
        repeat (2) step();
        reset_n = 1'b1;

        // A press held across reset produces no event until released and pressed again.
        repeat (8) step();
        btn_start_stop = 1'b1;
        repeat (4) step();
        reset_n = 1'b0;
        model_reset();
        repeat (2) step();
        reset_n = 1'b1;
        repeat (40) step();
        check("held_state", 32'(state), 32'(S_IDLE));
        btn_start_stop = 1'b0;
        repeat (16) step();
        press(1'b1, 1'b0, 3);
        check("repress_state", 32'(state), 32'(S_RUN));

        // Random bouncing buttons and count_max against the model.
        hold[0] = 0;
        hold[1] = 0;
        for (int c = 0; c < 600; c++) begin
            for (int b = 0; b < 2; b++) begin
                if (hold[b] == 0) begin
                    if (b == 0) btn_start_stop = 1'($urandom_range(0, 1));
                    else        btn_lap_clear  = 1'($urandom_range(0, 1));
                    hold[b] = int'($urandom_range(1, 20));
                end
                hold[b]--;
            end
            count_max = ($urandom_range(0, 15) == 0);
            if (c == 300) begin
                reset_n = 1'b0;
                model_reset();
            end
            if (c == 303) reset_n = 1'b1;
            step();
        end

        btn_start_stop = 1'b0;
        btn_lap_clear  = 1'b0;
        count_max      = 1'b0;
        repeat (4) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
